// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with 3-sample majority vote and a one-word AXI4-Stream output.
// Define UART_RX_PARITY_EN to receive a parity bit and report mismatches on M_axis_tuser[1].
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] M_axis_tdata,
    output logic                 M_axis_tvalid,
    input  logic                 M_axis_tready,
    output logic [1:0]           M_axis_tuser,
    output logic                 Overrun
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [3:0]             bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [1:0]             samp_reg, samp_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   parity_err_reg, parity_err_next;
    logic                   rx_meta_reg, rx_sync_reg, rx_sync_q_reg;
    logic [1:0]             fill_reg;
    logic [DATA_BITS-1:0]   tdata_reg;
    logic [1:0]             tuser_reg;
    logic                   tvalid_reg, overrun_reg;
    logic                   start_edge, maj, at_mid, at_last;
    logic                   commit, commit_frame_err;

    // The synchroniser resets to 1, so an edge only counts once all three flops hold real line samples;
    // a line held low across reset release therefore never looks like a start bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            rx_sync_q_reg <= 1'b1;
            fill_reg      <= 2'd0;
        end else begin
            rx_meta_reg   <= Rx;
            rx_sync_reg   <= rx_meta_reg;
            rx_sync_q_reg <= rx_sync_reg;
            if (fill_reg != 2'd3)
                fill_reg <= fill_reg + 2'd1;
        end
    end

    assign start_edge = !rx_sync_reg && rx_sync_q_reg && (fill_reg == 2'd3);
    assign maj        = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync_reg) | (samp_reg[1] & rx_sync_reg);
    assign at_mid     = (cnt_reg == CNT_MID);
    assign at_last    = (cnt_reg == CNT_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            samp_reg       <= '0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            samp_reg       <= samp_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = at_last ? '0 : cnt_reg + 1'b1;
        bit_idx_next     = bit_idx_reg;
        shift_next       = shift_reg;
        samp_next        = samp_reg;
        frame_err_next   = frame_err_reg;
        parity_err_next  = parity_err_reg;
        commit           = 1'b0;
        commit_frame_err = 1'b0;
        if (cnt_reg == CNT_S0)
            samp_next[0] = rx_sync_reg;
        if (cnt_reg == CNT_S1)
            samp_next[1] = rx_sync_reg;
        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (start_edge) begin
                    state_next      = START;
                    frame_err_next  = 1'b0;
                    parity_err_next = 1'b0;
                end
            end
            START: begin
                if (at_mid && maj) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (at_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (at_mid)
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_idx_reg == DATA_LAST) begin
                        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_mid)
                    parity_err_next = (^shift_reg) ^ maj ^ 1'(PARITY_ODD);
                if (at_last)
                    state_next = STOP;
            end
`endif
            STOP: begin
                if (at_mid) begin
                    if (!maj)
                        frame_err_next = 1'b1;
                    // The last stop bit is not waited out, so the next start edge is caught promptly.
                    if (bit_idx_reg == STOP_LAST) begin
                        commit           = 1'b1;
                        commit_frame_err = frame_err_reg | ~maj;
                        state_next       = IDLE;
                        cnt_next         = '0;
                    end
                end else if (at_last) begin
                    bit_idx_next = bit_idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tdata_reg   <= '0;
            tuser_reg   <= '0;
            tvalid_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (commit) begin
                if (!tvalid_reg || M_axis_tready) begin
                    tdata_reg  <= shift_reg;
`ifdef UART_RX_PARITY_EN
                    tuser_reg  <= {parity_err_reg, commit_frame_err};
`else
                    tuser_reg  <= {1'b0, commit_frame_err};
`endif
                    tvalid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (tvalid_reg && M_axis_tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign M_axis_tdata  = tdata_reg;
    assign M_axis_tuser  = tuser_reg;
    assign M_axis_tvalid = tvalid_reg;
    assign Overrun       = overrun_reg;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1/16x instance, 9-bit 2-stop 8x instance, and a 7-bit parity
// instance when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // tvalid rise relative to the negedge the start bit is driven: 3 cycles to START, then the decision
    localparam int LAT_A = 3 + (1 + 8 + PAR_EN + 1 - 1) * 16 + 8 + 1;
    localparam int LAT_B = 3 + (1 + 9 + PAR_EN + 2 - 1) * 8 + 4 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic line = 1'b1;
    int   sel = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rx_a, rx_b;
    logic [7:0] tdata_a;
    logic [8:0] tdata_b;
    logic [1:0] tuser_a, tuser_b;
    logic       tvalid_a, tvalid_b, ovr_a, ovr_b;
    logic       tready_a = 1'b1, tready_b = 1'b1;
    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;

    uart_rx_param dut_a (
        .Clk(clk), .Rst(rst), .Rx(rx_a),
        .M_axis_tdata(tdata_a), .M_axis_tvalid(tvalid_a), .M_axis_tready(tready_a),
        .M_axis_tuser(tuser_a), .Overrun(ovr_a)
    );

    uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(8), .STOP_BITS(2)) dut_b (
        .Clk(clk), .Rst(rst), .Rx(rx_b),
        .M_axis_tdata(tdata_b), .M_axis_tvalid(tvalid_b), .M_axis_tready(tready_b),
        .M_axis_tuser(tuser_b), .Overrun(ovr_b)
    );

`ifdef UART_RX_PARITY_EN
    logic       rx_c, tvalid_c, ovr_c;
    logic [6:0] tdata_c;
    logic [1:0] tuser_c;
    logic       tready_c = 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;
    uart_rx_param #(.DATA_BITS(7), .PARITY_ODD(0)) dut_c (
        .Clk(clk), .Rst(rst), .Rx(rx_c),
        .M_axis_tdata(tdata_c), .M_axis_tvalid(tvalid_c), .M_axis_tready(tready_c),
        .M_axis_tuser(tuser_c), .Overrun(ovr_c)
    );
    int         cap_n_c = 0;
    logic [8:0] cap_d_c[$];
    logic [1:0] cap_u_c[$];
    always begin
        @(negedge clk); #2;
        if (tvalid_c && tready_c) begin
            cap_d_c.push_back({2'b00, tdata_c}); cap_u_c.push_back(tuser_c); cap_n_c++;
        end
    end
`endif

    // Monitors sample 2 ns after the falling edge, after the bench has driven its inputs.
    int         cap_n_a = 0, valid_cyc_a = 0, ovr_cnt_a = 0, rise_a = -1;
    int         cap_n_b = 0, rise_b = -1;
    logic       prev_v_a = 1'b0, prev_v_b = 1'b0;
    logic [8:0] cap_d_a[$], cap_d_b[$];
    logic [1:0] cap_u_a[$], cap_u_b[$];
    always begin
        @(negedge clk); #2;
        if (tvalid_a) valid_cyc_a++;
        if (tvalid_a && !prev_v_a) rise_a = cyc;
        prev_v_a = tvalid_a;
        if (ovr_a) ovr_cnt_a++;
        if (tvalid_a && tready_a) begin
            cap_d_a.push_back({1'b0, tdata_a}); cap_u_a.push_back(tuser_a); cap_n_a++;
        end
        if (tvalid_b && !prev_v_b) rise_b = cyc;
        prev_v_b = tvalid_b;
        if (tvalid_b && tready_b) begin
            cap_d_b.push_back(tdata_b); cap_u_b.push_back(tuser_b); cap_n_b++;
        end
    end

    int n_checks = 0, n_fail = 0;
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    int frame_t0 = 0;
    // Drives one frame LSB-first; glitch_at inverts a single cycle, abort_after > 0 stops after that many bits.
    task automatic send_frame(input int s, input int os, input int nb, input int nstop,
                              input logic [8:0] data, input int has_par, input logic par,
                              input logic stop_val, input int glitch_at, input int abort_after,
                              input int idle);
        logic [15:0] bits;
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1 + i] = data[i];
        n = 1 + nb;
        if (has_par != 0) begin
            bits[n] = par;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stop_val;
            n++;
        end
        if (abort_after > 0 && abort_after < n) n = abort_after;
        sel = s;
        @(negedge clk);
        frame_t0 = cyc;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < os; k++) begin
                line = ((b * os + k) == glitch_at) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
        if (abort_after == 0) begin
            line = 1'b1;
            repeat (idle) @(negedge clk);
        end
    endtask

    int n0, v0, o0, t0;
    initial begin
        repeat (3) @(negedge clk);
        #3;
        check_value("reset_tvalid", tvalid_a, 0);
        check_value("reset_tdata", tdata_a, 0);
        check_value("reset_tuser", tuser_a, 0);
        check_value("reset_overrun", ovr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic 8N1 0xA5
        n0 = cap_n_a; v0 = valid_cyc_a;
        send_frame(0, 16, 8, 1, 9'h0A5, PAR_EN, ^8'hA5, 1'b1, -1, 0, 32);
        t0 = frame_t0;
        check_value("basic_count", cap_n_a - n0, 1);
        check_value("basic_data", cap_d_a[n0], 32'hA5);
        check_value("basic_tuser", cap_u_a[n0], 0);
        check_value("basic_valid_cycles", valid_cyc_a - v0, 1);
        check_value("basic_latency", rise_a - t0, LAT_A);

        // False start: 4-cycle low glitch, then 0x3C
        n0 = cap_n_a; v0 = valid_cyc_a;
        sel = 0;
        @(negedge clk); line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (40) @(negedge clk);
        check_value("false_start_count", cap_n_a - n0, 0);
        check_value("false_start_valid", valid_cyc_a - v0, 0);
        send_frame(0, 16, 8, 1, 9'h03C, PAR_EN, ^8'h3C, 1'b1, -1, 0, 32);
        check_value("after_glitch_count", cap_n_a - n0, 1);
        check_value("after_glitch_data", cap_d_a[n0], 32'h3C);
        check_value("after_glitch_tuser", cap_u_a[n0], 0);

        // Framing error
        n0 = cap_n_a;
        send_frame(0, 16, 8, 1, 9'h055, PAR_EN, ^8'h55, 1'b0, -1, 0, 32);
        check_value("frame_err_count", cap_n_a - n0, 1);
        check_value("frame_err_data", cap_d_a[n0], 32'h55);
        check_value("frame_err_tuser", cap_u_a[n0], 32'h1);

        // Overrun with tready low
        tready_a = 1'b0;
        n0 = cap_n_a; o0 = ovr_cnt_a;
        send_frame(0, 16, 8, 1, 9'h011, PAR_EN, ^8'h11, 1'b1, -1, 0, 0);
        send_frame(0, 16, 8, 1, 9'h022, PAR_EN, ^8'h22, 1'b1, -1, 0, 32);
        #3;
        check_value("overrun_tvalid_held", tvalid_a, 1);
        check_value("overrun_data_held", tdata_a, 32'h11);
        check_value("overrun_pulses", ovr_cnt_a - o0, 1);
        check_value("overrun_no_transfer", cap_n_a - n0, 0);
        @(negedge clk);
        tready_a = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check_value("overrun_drain_count", cap_n_a - n0, 1);
        check_value("overrun_drain_data", cap_d_a[n0], 32'h11);
        check_value("overrun_tvalid_fall", tvalid_a, 0);

        // 9 data bits, 2 stop bits, 8x; single-cycle glitch on the decision sample of data bit 3
        n0 = cap_n_b;
        send_frame(1, 8, 9, 2, 9'h1FF, PAR_EN, ^9'h1FF, 1'b1, 4 * 8 + 5, 0, 24);
        t0 = frame_t0;
        check_value("wide_count", cap_n_b - n0, 1);
        check_value("wide_data", cap_d_b[n0], 32'h1FF);
        check_value("wide_tuser", cap_u_b[n0], 0);
        check_value("wide_latency", rise_b - t0, LAT_B);

`ifdef UART_RX_PARITY_EN
        n0 = cap_n_c;
        send_frame(2, 16, 7, 1, 9'h041, 1, 1'b1, 1'b1, -1, 0, 32);
        send_frame(2, 16, 7, 1, 9'h041, 1, 1'b0, 1'b1, -1, 0, 32);
        check_value("parity_count", cap_n_c - n0, 2);
        check_value("parity_bad_data", cap_d_c[n0], 32'h41);
        check_value("parity_bad_tuser", cap_u_c[n0], 32'h2);
        check_value("parity_good_tuser", cap_u_c[n0 + 1], 0);
`endif

        // Reset mid-frame with a word held
        tready_a = 1'b0;
        send_frame(0, 16, 8, 1, 9'h05A, PAR_EN, ^8'h5A, 1'b1, -1, 0, 32);
        #3;
        check_value("hold_before_reset", tvalid_a, 1);
        send_frame(0, 16, 8, 1, 9'h0F0, PAR_EN, ^8'hF0, 1'b1, -1, 5, 0);
        rst = 1'b1;
        #1;
        check_value("midreset_tvalid", tvalid_a, 0);
        check_value("midreset_tdata", tdata_a, 0);
        check_value("midreset_tuser", tuser_a, 0);
        check_value("midreset_overrun", ovr_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tready_a = 1'b1;
        #3;
        n0 = cap_n_a; v0 = valid_cyc_a;
        repeat (100) @(negedge clk);
        line = 1'b1;
        repeat (40) @(negedge clk);
        check_value("stuck_low_count", cap_n_a - n0, 0);
        check_value("stuck_low_valid", valid_cyc_a - v0, 0);
        send_frame(0, 16, 8, 1, 9'h00F, PAR_EN, ^8'h0F, 1'b1, -1, 0, 32);
        check_value("post_reset_count", cap_n_a - n0, 1);
        check_value("post_reset_data", cap_d_a[n0], 32'h0F);
        check_value("post_reset_tuser", cap_u_a[n0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
